// File: rtl/addsub_rs_scheduler.sv
// rtl/addsub_rs_scheduler.sv - round-robin issue scheduler for the shared add/sub FU
// Picks a ready RS entry, runs the FU, then holds the tagged result on the CDB until acked.
module addsub_rs_scheduler #(
    parameter int N_RS    = 3,
    parameter int DATA_W  = 9,
    parameter int TAG_W   = 3,
    parameter int TIMEOUT = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_RS-1:0]         rs_ready,
    input  logic [3*N_RS-1:0]       rs_op,
    input  logic [DATA_W*N_RS-1:0]  rs_vj,
    input  logic [DATA_W*N_RS-1:0]  rs_vk,
    input  logic [TAG_W*N_RS-1:0]   rs_tag,
    output logic [N_RS-1:0]         rs_grant,
    output logic                    fu_run,
    output logic [DATA_W-1:0]       fu_x,
    output logic [DATA_W-1:0]       fu_y,
    output logic [2:0]              fu_op,
    input  logic                    fu_done,
    input  logic [DATA_W-1:0]       fu_result,
    output logic                    cdb_valid,
    output logic [DATA_W-1:0]       cdb_data,
    output logic [TAG_W-1:0]        cdb_tag,
    output logic                    cdb_err,
    input  logic                    cdb_ack,
    output logic                    busy
);
    localparam int PTR_W = (N_RS > 1) ? $clog2(N_RS) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;

    logic [1:0]        state;
    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  pick;
    logic              pick_valid;
    logic [CNT_W-1:0]  cycle_cnt;
    logic [N_RS-1:0]   grant_vec;
    logic [2:0]        sel_op;
    logic [DATA_W-1:0] sel_vj;
    logic [DATA_W-1:0] sel_vk;
    logic [TAG_W-1:0]  sel_tag;
    logic              sel_legal;

    // Scan from rr_ptr upward with wrap; the first ready entry wins.
    always_comb begin
        int               idx;
        logic [PTR_W-1:0] cand;
        idx        = 0;
        cand       = '0;
        pick_valid = 1'b0;
        pick       = '0;
        for (int k = 0; k < N_RS; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_RS) begin
                idx = idx - N_RS;
            end
            cand = PTR_W'(idx);
            if (!pick_valid && rs_ready[cand]) begin
                pick_valid = 1'b1;
                pick       = cand;
            end
        end
    end

    always_comb begin
        sel_op    = '0;
        sel_vj    = '0;
        sel_vk    = '0;
        sel_tag   = '0;
        grant_vec = '0;
        for (int k = 0; k < N_RS; k++) begin
            if (PTR_W'(k) == pick) begin
                sel_op       = rs_op[3*k +: 3];
                sel_vj       = rs_vj[DATA_W*k +: DATA_W];
                sel_vk       = rs_vk[DATA_W*k +: DATA_W];
                sel_tag      = rs_tag[TAG_W*k +: TAG_W];
                grant_vec[k] = pick_valid;
            end
        end
        sel_legal = (sel_op[2:1] == 2'b00);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            cycle_cnt <= '0;
            rs_grant  <= '0;
            fu_run    <= 1'b0;
            fu_x      <= '0;
            fu_y      <= '0;
            fu_op     <= '0;
            cdb_valid <= 1'b0;
            cdb_data  <= '0;
            cdb_tag   <= '0;
            cdb_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rs_grant <= '0;
            case (state)
                S_IDLE: begin
                    if (pick_valid) begin
                        rs_grant <= grant_vec;
                        rr_ptr   <= (pick == PTR_W'(N_RS - 1)) ? '0 : pick + 1'b1;
                        fu_x     <= sel_vj;
                        fu_y     <= sel_vk;
                        fu_op    <= sel_op;
                        cdb_tag  <= sel_tag;
                        busy     <= 1'b1;
                        if (sel_legal) begin
                            state     <= S_EXEC;
                            fu_run    <= 1'b1;
                            cycle_cnt <= CNT_W'(1);
                        end else begin
                            // Illegal opcode skips the FU and reports straight away.
                            state     <= S_WB;
                            cdb_valid <= 1'b1;
                            cdb_data  <= '0;
                            cdb_err   <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    if (fu_done) begin
                        state     <= S_WB;
                        fu_run    <= 1'b0;
                        cdb_valid <= 1'b1;
                        cdb_data  <= fu_result;
                        cdb_err   <= 1'b0;
                    end else if (cycle_cnt == CNT_W'(TIMEOUT)) begin
                        state     <= S_WB;
                        fu_run    <= 1'b0;
                        cdb_valid <= 1'b1;
                        cdb_data  <= '0;
                        cdb_err   <= 1'b1;
                    end else begin
                        cycle_cnt <= cycle_cnt + 1'b1;
                    end
                end
                S_WB: begin
                    if (cdb_ack) begin
                        state     <= S_IDLE;
                        cdb_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_addsub_rs_scheduler.sv
// tb/tb_addsub_rs_scheduler.sv - scoreboard bench for addsub_rs_scheduler
// Driver predicts each issue from round-robin rules; a negedge monitor checks grant, FU and CDB.
module tb_addsub_rs_scheduler;
    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic [2:0]  rs_ready  = '0;
    logic [8:0]  rs_op     = '0;
    logic [26:0] rs_vj     = '0;
    logic [26:0] rs_vk     = '0;
    logic [8:0]  rs_tag    = '0;
    logic        fu_done   = 1'b0;
    logic [8:0]  fu_result = '0;
    logic        cdb_ack   = 1'b0;
    logic [2:0]  rs_grant;
    logic        fu_run;
    logic [8:0]  fu_x;
    logic [8:0]  fu_y;
    logic [2:0]  fu_op;
    logic        cdb_valid;
    logic [8:0]  cdb_data;
    logic [2:0]  cdb_tag;
    logic        cdb_err;
    logic        busy;

    always #5 clk = ~clk;

    addsub_rs_scheduler #(.N_RS(3), .DATA_W(9), .TAG_W(3), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .rs_ready(rs_ready), .rs_op(rs_op), .rs_vj(rs_vj),
        .rs_vk(rs_vk), .rs_tag(rs_tag), .rs_grant(rs_grant), .fu_run(fu_run), .fu_x(fu_x),
        .fu_y(fu_y), .fu_op(fu_op), .fu_done(fu_done), .fu_result(fu_result),
        .cdb_valid(cdb_valid), .cdb_data(cdb_data), .cdb_tag(cdb_tag), .cdb_err(cdb_err),
        .cdb_ack(cdb_ack), .busy(busy)
    );

    typedef struct {
        logic [2:0] grant;
        logic [8:0] x;
        logic [8:0] y;
        logic [2:0] op;
        logic [2:0] tag;
        logic [8:0] data;
        logic       err;
        int         run_len;
        int         wb_len;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   n_pass     = 0;
    int   n_total    = 0;
    int   model_ptr  = 0;
    int   fu_lat     = 0;
    int   ack_delay  = 0;
    bit   cur_active = 0;
    bit   prev_grant = 0;
    int   run_cnt    = 0;
    int   wb_cnt     = 0;
    int   fcnt       = 0;
    int   ack_cnt    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_grant"}, 32'(rs_grant), 0);
        check({tag, "_fu_run"}, 32'(fu_run), 0);
        check({tag, "_fu_x"}, 32'(fu_x), 0);
        check({tag, "_fu_y"}, 32'(fu_y), 0);
        check({tag, "_fu_op"}, 32'(fu_op), 0);
        check({tag, "_cdb_valid"}, 32'(cdb_valid), 0);
        check({tag, "_cdb_data"}, 32'(cdb_data), 0);
        check({tag, "_cdb_tag"}, 32'(cdb_tag), 0);
        check({tag, "_cdb_err"}, 32'(cdb_err), 0);
        check({tag, "_busy"}, 32'(busy), 0);
    endtask

    task automatic set_entry(input int i, input logic [2:0] op, input logic [8:0] vj,
                             input logic [8:0] vk, input logic [2:0] tag);
        rs_op  = (rs_op  & ~(9'h7    << (3*i))) | (9'(op)  << (3*i));
        rs_vj  = (rs_vj  & ~(27'h1FF << (9*i))) | (27'(vj) << (9*i));
        rs_vk  = (rs_vk  & ~(27'h1FF << (9*i))) | (27'(vk) << (9*i));
        rs_tag = (rs_tag & ~(9'h7    << (3*i))) | (9'(tag) << (3*i));
    endtask

    task automatic rand_entries(input bit allow_illegal);
        for (int i = 0; i < 3; i++) begin
            logic [2:0] op;
            if (allow_illegal && $urandom_range(0, 3) == 0) op = 3'($urandom_range(2, 7));
            else op = 3'($urandom_range(0, 1));
            set_entry(i, op, 9'($urandom), 9'($urandom), 3'($urandom));
        end
    endtask

    // Reference: first ready entry at or after the model pointer wins; FU answers on cycle lat.
    task automatic expect_op(input logic [2:0] mask, input int lat, input int ackd);
        int   w;
        exp_t e;
        w = -1;
        for (int k = 0; k < 3; k++) begin
            int idx;
            idx = (model_ptr + k) % 3;
            if (w < 0 && ((mask >> idx) & 3'b001) != 3'b000) w = idx;
        end
        model_ptr = (w + 1) % 3;
        e.grant = 3'(1 << w);
        e.op    = 3'(rs_op >> (3*w));
        e.x     = 9'(rs_vj >> (9*w));
        e.y     = 9'(rs_vk >> (9*w));
        e.tag   = 3'(rs_tag >> (3*w));
        if (e.op > 3'd1) begin
            e.data = 9'd0; e.err = 1'b1; e.run_len = 0;
        end else if (lat >= 1 && lat <= 8) begin
            e.data = (e.op == 3'd0) ? e.x + e.y : e.x - e.y;
            e.err = 1'b0; e.run_len = lat;
        end else begin
            e.data = 9'd0; e.err = 1'b1; e.run_len = 8;
        end
        e.wb_len = ackd + 1;
        exp_q.push_back(e);
        fu_lat    = lat;
        ack_delay = ackd;
    endtask

    task automatic wait_grant(output bit seen);
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge clk); #1;
            if (rs_grant != 3'b000) seen = 1;
        end
        if (!seen) begin
            n_total++;
            $display("FAIL grant_timeout: no grant within 20 cycles, ready %b", rs_ready);
            exp_q.delete();
        end
    endtask

    task automatic run_op(input logic [2:0] mask, input bit hold, input int lat, input int ackd);
        bit seen;
        expect_op(mask, lat, ackd);
        rs_ready = mask;
        wait_grant(seen);
        if (!hold || !seen) rs_ready = '0;
        if (seen) begin
            seen = 0;
            for (int c = 0; c < 40 && !seen; c++) begin
                @(posedge clk); #1;
                if (!busy) seen = 1;
            end
            if (!seen) begin
                n_total++;
                $display("FAIL done_timeout: busy still %b after 40 cycles", busy);
            end
        end
    endtask

    // FU model: done on the lat-th run cycle; noise on done/result whenever not running.
    always @(posedge clk) begin
        #1;
        if (fu_run) begin
            fcnt++;
            fu_done   = (fcnt == fu_lat);
            fu_result = fu_done ? ((fu_op[0]) ? fu_x - fu_y : fu_x + fu_y) : 9'($urandom);
        end else begin
            fcnt      = 0;
            fu_done   = 1'($urandom);
            fu_result = 9'($urandom);
        end
    end

    always @(posedge clk) begin
        #1;
        if (cdb_valid) begin
            ack_cnt++;
            cdb_ack = (ack_cnt > ack_delay);
        end else begin
            ack_cnt = 0;
            cdb_ack = (ack_delay == 0) ? 1'b1 : 1'($urandom);
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            cur_active = 0;
            prev_grant = 0;
        end else begin
            if (prev_grant) check("grant_pulse", 32'(rs_grant), 0);
            prev_grant = (rs_grant != 3'b000);
            if (rs_grant != 3'b000) begin
                check("grant_while_active", 32'(cur_active), 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_grant", 32'(rs_grant), 0);
                end else begin
                    cur = exp_q.pop_front();
                    check("grant", 32'(rs_grant), 32'(cur.grant));
                    cur_active = 1;
                    run_cnt = 0;
                    wb_cnt = 0;
                end
            end else if (!cur_active) begin
                check("idle_busy", 32'(busy), 0);
                check("idle_cdb_valid", 32'(cdb_valid), 0);
                check("idle_fu_run", 32'(fu_run), 0);
            end
            if (cur_active) begin
                check("active_busy", 32'(busy), 1);
                if (fu_run) begin
                    run_cnt++;
                    check("fu_x", 32'(fu_x), 32'(cur.x));
                    check("fu_y", 32'(fu_y), 32'(cur.y));
                    check("fu_op", 32'(fu_op), 32'(cur.op));
                    check("exec_cdb_valid", 32'(cdb_valid), 0);
                end
                if (cdb_valid) begin
                    wb_cnt++;
                    check("cdb_data", 32'(cdb_data), 32'(cur.data));
                    check("cdb_tag", 32'(cdb_tag), 32'(cur.tag));
                    check("cdb_err", 32'(cdb_err), 32'(cur.err));
                    check("wb_fu_run", 32'(fu_run), 0);
                    if (rs_grant == 3'b000) check("wb_no_grant", 32'(rs_grant), 0);
                    if (cdb_ack) begin
                        check("exec_cycles", 32'(run_cnt), 32'(cur.run_len));
                        check("wb_cycles", 32'(wb_cnt), 32'(cur.wb_len));
                        cur_active = 0;
                    end
                end
            end
        end
    end

    initial begin
        bit seen;
        logic [2:0] mask;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        for (int n = 0; n < 4; n++) begin
            rand_entries(0);
            run_op(3'b111, 1, $urandom_range(1, 4), 0);
        end
        rs_ready = '0;

        rand_entries(0);
        set_entry(1, 3'b000, 9'd5, 9'd7, 3'd2);
        run_op(3'b010, 0, 3, 2);

        rand_entries(0);
        set_entry(0, 3'b011, 9'($urandom), 9'($urandom), 3'($urandom));
        run_op(3'b001, 0, 3, 0);

        rand_entries(0);
        run_op(3'b100, 0, 0, 1);

        rand_entries(0);
        run_op(3'b111, 1, 2, 5);
        rs_ready = '0;

        for (int n = 0; n < 40; n++) begin
            rand_entries(1);
            mask = 3'($urandom_range(1, 7));
            run_op(mask, 1'($urandom), $urandom_range(0, 9), $urandom_range(0, 3));
        end
        rs_ready = '0;

        rand_entries(0);
        expect_op(3'b010, 0, 0);
        rs_ready = 3'b010;
        wait_grant(seen);
        rs_ready = '0;
        repeat (3) @(posedge clk);
        #1;
        check("exec_before_reset", 32'(fu_run), 1);
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        check_zero("mid_reset");
        @(posedge clk); #1;
        reset = 1'b0;
        model_ptr = 0;
        rand_entries(0);
        run_op(3'b111, 0, 2, 0);
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
